// File: rtl/pipe_ctrl.sv
// Pipeline hazard / exception controller: load-use stalls, branch and ERET
// redirects, and a RUN -> FLUSH -> VECTOR exception sequence.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             id_br,
  input  logic [31:0]      id_br_target,
  input  logic             id_exception,
  input  logic [4:0]       id_cause,
  input  logic [31:0]      id_pc,
  input  logic             id_eret,
  input  logic             cnt_clr,
  output logic             hold_pc,
  output logic             hold_if,
  output logic             bubble_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc,
  output logic [4:0]       cause,
  output logic             exc_active,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, FLUSH, VECTOR} state_t;

  localparam logic [3:0] FC_INIT = 4'(FLUSH_CYCLES - 1);

  state_t           r_state, w_next;
  logic [3:0]       r_fcnt, w_fcnt_next;
  logic [31:0]      r_epc;
  logic [4:0]       r_cause;
  logic [CNT_W-1:0] r_stall;
  logic             w_hazard, w_take_exc, w_stall;

  assign w_hazard   = ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign w_take_exc = (r_state == RUN) & id_exception;
  assign w_stall    = (r_state == RUN) & ~id_exception & w_hazard;

  assign epc         = r_epc;
  assign cause       = r_cause;
  assign stall_count = r_stall;

  always_comb begin
    w_next      = r_state;
    w_fcnt_next = r_fcnt;
    hold_pc     = 1'b0;
    hold_if     = 1'b0;
    bubble_id   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    exc_active  = (r_state != RUN);
    case (r_state)
      RUN: begin
        if (id_exception) begin
          bubble_id   = 1'b1;
          w_next      = FLUSH;
          w_fcnt_next = FC_INIT;
        end else if (w_hazard) begin
          hold_pc   = 1'b1;
          hold_if   = 1'b1;
          bubble_id = 1'b1;
        end else if (id_eret) begin
          pc_redirect = 1'b1;
          redirect_pc = r_epc;
          flush_id    = 1'b1;
        end else if (id_br) begin
          pc_redirect = 1'b1;
          redirect_pc = id_br_target;
          flush_id    = 1'b1;
        end
      end
      FLUSH: begin
        hold_pc  = 1'b1;
        hold_if  = 1'b1;
        flush_id = 1'b1;
        flush_ex = 1'b1;
        if (r_fcnt == '0) w_next = VECTOR;
        else              w_fcnt_next = r_fcnt - 4'd1;
      end
      VECTOR: begin
        pc_redirect = 1'b1;
        redirect_pc = EXC_VECTOR;
        flush_id    = 1'b1;
        w_next      = RUN;
      end
      default: w_next = RUN;
    endcase
    // Reset must silence outputs even while ID-stage inputs still show a hazard.
    if (!rst_n) begin
      hold_pc     = 1'b0;
      hold_if     = 1'b0;
      bubble_id   = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      pc_redirect = 1'b0;
      redirect_pc = '0;
      exc_active  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_fcnt  <= '0;
      r_epc   <= '0;
      r_cause <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      r_fcnt  <= w_fcnt_next;
      if (w_take_exc) begin
        r_epc   <= id_pc;
        r_cause <= id_cause;
      end
      if (cnt_clr)                    r_stall <= '0;
      else if (w_stall && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed corner sequences,
// and randomized traffic against a cycle-count based reference model.
module tb_pipe_ctrl;

  localparam int unsigned CW   = 4;
  localparam int unsigned FC   = 2;
  localparam logic [31:0] EVEC = 32'h0000_0080;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rt, id_cause;
  logic          ex_mem_read, id_br, id_exception, id_eret, cnt_clr;
  logic [31:0]   id_br_target, id_pc;
  logic          hold_pc, hold_if, bubble_id, flush_id, flush_ex, pc_redirect, exc_active;
  logic [31:0]   redirect_pc, epc;
  logic [4:0]    cause;
  logic [CW-1:0] stall_count;

  pipe_ctrl #(.EXC_VECTOR(EVEC), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .id_br(id_br), .id_br_target(id_br_target),
    .id_exception(id_exception), .id_cause(id_cause), .id_pc(id_pc),
    .id_eret(id_eret), .cnt_clr(cnt_clr), .hold_pc(hold_pc), .hold_if(hold_if),
    .bubble_id(bubble_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .epc(epc),
    .cause(cause), .exc_active(exc_active), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: m_phase counts cycles since the exception was taken
  // (0 = running, 1..FC = flushing, FC+1 = vectoring).
  int          m_phase;
  logic [31:0] m_epc;
  logic [4:0]  m_cause;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit hz();
    return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
  endfunction

  task automatic clr_in();
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_mem_read = 0; id_br = 0; id_br_target = 0;
    id_exception = 0; id_cause = 0; id_pc = 0; id_eret = 0; cnt_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_hold_pc", hold_pc, 0);   chk("rst_hold_if", hold_if, 0);
    chk("rst_bubble", bubble_id, 0);  chk("rst_flush_id", flush_id, 0);
    chk("rst_flush_ex", flush_ex, 0); chk("rst_redirect", pc_redirect, 0);
    chk("rst_rpc", redirect_pc, 0);   chk("rst_exc_active", exc_active, 0);
    chk("rst_epc", epc, 0);           chk("rst_cause", cause, 0);
    chk("rst_cnt", stall_count, 0);
    m_phase = 0; m_epc = 0; m_cause = 0; m_cnt = 0;
    rst_n = 1'b1;
  endtask

  // Called just after a rising edge: check outputs at the falling edge, then
  // advance the model across the next rising edge.
  task automatic step();
    logic e_hpc, e_hif, e_bub, e_fid, e_fex, e_red;
    logic [31:0] e_rpc;
    e_hpc = 0; e_hif = 0; e_bub = 0; e_fid = 0; e_fex = 0; e_red = 0; e_rpc = 0;
    if (m_phase == 0) begin
      if (id_exception) e_bub = 1;
      else if (hz()) begin e_hpc = 1; e_hif = 1; e_bub = 1; end
      else if (id_eret) begin e_red = 1; e_rpc = m_epc; e_fid = 1; end
      else if (id_br) begin e_red = 1; e_rpc = id_br_target; e_fid = 1; end
    end else if (m_phase <= FC) begin
      e_hpc = 1; e_hif = 1; e_fid = 1; e_fex = 1;
    end else begin
      e_red = 1; e_rpc = EVEC; e_fid = 1;
    end
    @(negedge clk);
    chk("hold_pc", hold_pc, e_hpc);      chk("hold_if", hold_if, e_hif);
    chk("bubble_id", bubble_id, e_bub);  chk("flush_id", flush_id, e_fid);
    chk("flush_ex", flush_ex, e_fex);    chk("pc_redirect", pc_redirect, e_red);
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("exc_active", exc_active, m_phase != 0);
    chk("epc", epc, m_epc);              chk("cause", cause, m_cause);
    chk("stall_count", stall_count, m_cnt);
    @(posedge clk);
    if (cnt_clr) m_cnt = 0;
    else if (m_phase == 0 && !id_exception && hz() && m_cnt < CMAX) m_cnt++;
    if (m_phase == 0) begin
      if (id_exception) begin m_epc = id_pc; m_cause = id_cause; m_phase = 1; end
    end else if (m_phase == FC + 1) m_phase = 0;
    else m_phase++;
    #1;
  endtask

  typedef struct {
    logic [4:0]  rs, rt, exrt;
    logic        mr, br;
    logic [31:0] tgt;
    logic        exc, eret;
    logic        hold, bub, fid, red;
    logic [31:0] rpc;
  } vec_t;

  function automatic vec_t mk(int rs, int rt, int exrt, int mr, int br, int tgt,
                              int exc, int eret, int hold, int bub, int fid, int red, int rpc);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.exrt = 5'(exrt); v.mr = mr[0]; v.br = br[0];
    v.tgt = 32'(tgt); v.exc = exc[0]; v.eret = eret[0]; v.hold = hold[0];
    v.bub = bub[0]; v.fid = fid[0]; v.red = red[0]; v.rpc = 32'(rpc);
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    tbl[0] = mk(5, 0, 5, 1, 0, 0,      0, 0,  1, 1, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 1, 0, 0,      0, 0,  0, 0, 0, 0, 0);
    tbl[2] = mk(3, 7, 7, 1, 0, 0,      0, 0,  1, 1, 0, 0, 0);
    tbl[3] = mk(5, 0, 5, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0);
    tbl[4] = mk(1, 2, 9, 0, 1, 'h100,  0, 0,  0, 0, 1, 1, 'h100);
    tbl[5] = mk(5, 0, 5, 1, 1, 'h100,  0, 0,  1, 1, 0, 0, 0);
    tbl[6] = mk(5, 0, 5, 1, 1, 'h100,  1, 0,  0, 1, 0, 0, 0);
    tbl[7] = mk(0, 0, 0, 0, 1, 'h200,  0, 1,  0, 0, 1, 1, 0);
    tbl[8] = mk(2, 2, 2, 1, 1, 'h300,  0, 1,  1, 1, 0, 0, 0);

    clr_in();
    do_reset();
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; ex_rt = tbl[i].exrt; ex_mem_read = tbl[i].mr;
      id_br = tbl[i].br; id_br_target = tbl[i].tgt; id_exception = tbl[i].exc;
      id_eret = tbl[i].eret; id_pc = 32'h44; id_cause = 5'd3;
      @(negedge clk);
      chk($sformatf("tbl%0d_hold_pc", i), hold_pc, tbl[i].hold);
      chk($sformatf("tbl%0d_hold_if", i), hold_if, tbl[i].hold);
      chk($sformatf("tbl%0d_bubble", i), bubble_id, tbl[i].bub);
      chk($sformatf("tbl%0d_flush_id", i), flush_id, tbl[i].fid);
      chk($sformatf("tbl%0d_flush_ex", i), flush_ex, 0);
      chk($sformatf("tbl%0d_redirect", i), pc_redirect, tbl[i].red);
      chk($sformatf("tbl%0d_rpc", i), redirect_pc, tbl[i].rpc);
      clr_in();
      do_reset();
      @(posedge clk); #1;
    end

    // Load-use stall counts once; ex_rt=0 never stalls.
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; step();
    chk("ldu_cnt_one", stall_count, 1);
    ex_rt = 0; id_rs = 0; step();
    chk("ldu_r0_cnt", stall_count, 1);
    clr_in();

    // Full exception sequence, exception during FLUSH ignored, then ERET.
    id_exception = 1; id_pc = 32'h40; id_cause = 5'd12; step();
    id_pc = 32'h999; id_cause = 5'd7; step();
    clr_in(); step();
    step();
    chk("exc_epc", epc, 32'h40);
    chk("exc_cause", cause, 12);
    chk("exc_done", exc_active, 0);
    id_eret = 1; step();
    clr_in();

    // Exception beats hazard and branch; stall counter untouched.
    id_exception = 1; id_pc = 32'h60; id_cause = 5'd4;
    ex_mem_read = 1; ex_rt = 3; id_rt = 3; id_br = 1; id_br_target = 32'h100;
    step();
    clr_in();
    chk("exc_pri_cnt", stall_count, 1);
    repeat (FC + 1) step();

    // Hazard holds a branch; branch acts once the hazard clears.
    ex_mem_read = 1; ex_rt = 9; id_rs = 9; id_br = 1; id_br_target = 32'h100; step();
    ex_mem_read = 0; step();
    clr_in();

    // Reset during the first FLUSH cycle.
    id_exception = 1; id_pc = 32'h70; id_cause = 5'd2; step();
    chk("flush_entered", exc_active, 1);
    do_reset();
    clr_in(); step();

    // Saturation under continuous hazard, then clear beats increment.
    ex_mem_read = 1; ex_rt = 1; id_rt = 1;
    repeat (CMAX + 4) step();
    chk("sat_cnt", stall_count, CMAX);
    cnt_clr = 1; step();
    chk("clr_cnt", stall_count, 0);
    clr_in();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3)); ex_mem_read = 1'($urandom_range(0, 1));
      id_br = 1'($urandom_range(0, 2) == 0); id_br_target = $urandom;
      id_exception = 1'($urandom_range(0, 9) == 0); id_cause = 5'($urandom);
      id_pc = $urandom; id_eret = 1'($urandom_range(0, 5) == 0);
      cnt_clr = 1'($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
